// File: rtl/of_stage_pipe.sv
// RV32IM decode stage: DEPTH-entry fetch FIFO feeding a registered, flow-controlled decoded packet.
// Optional M-extension decode is enabled by defining RV32M_DECODE_EN.
`timescale 1ns/1ps

package rv32_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [5:0] {
    ALU_OP_NOP,
    ALU_OP_LUI,
    ALU_OP_AUIPC,
    ALU_OP_JAL,
    ALU_OP_JALR,
    ALU_OP_BEQ,
    ALU_OP_BNE,
    ALU_OP_BLT,
    ALU_OP_BGE,
    ALU_OP_BLTU,
    ALU_OP_BGEU,
    ALU_OP_LB,
    ALU_OP_LH,
    ALU_OP_LW,
    ALU_OP_LBU,
    ALU_OP_LHU,
    ALU_OP_SB,
    ALU_OP_SH,
    ALU_OP_SW,
    ALU_OP_ADDI,
    ALU_OP_SLTI,
    ALU_OP_SLTIU,
    ALU_OP_XORI,
    ALU_OP_ORI,
    ALU_OP_ANDI,
    ALU_OP_SLLI,
    ALU_OP_SRLI,
    ALU_OP_SRAI,
    ALU_OP_ADD,
    ALU_OP_SUB,
    ALU_OP_SLL,
    ALU_OP_SLT,
    ALU_OP_SLTU,
    ALU_OP_XOR,
    ALU_OP_SRL,
    ALU_OP_SRA,
    ALU_OP_OR,
    ALU_OP_AND,
    ALU_OP_MUL,
    ALU_OP_MULH,
    ALU_OP_MULHSU,
    ALU_OP_MULHU,
    ALU_OP_DIV,
    ALU_OP_DIVU,
    ALU_OP_REM,
    ALU_OP_REMU
  } alu_op_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } rv32_if_packet_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm32;
    alu_op_t     alu_op;
    logic        dont_forward;
    logic        valid_opcode;
  } rv32_instr_packet_t;

  function automatic logic valid_opcode(input logic [6:0] opcode);
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

  // Loads have no result at the end of execute; branches and stores have no register result.
  function automatic logic dont_forward(input logic [6:0] opcode);
    case (opcode)
      OPC_LOAD, OPC_STORE, OPC_BRANCH: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

module of_stage_pipe
  import rv32_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               if_valid,
  output logic               if_ready,
  input  rv32_if_packet_t    if_packet,
  output logic               id_valid,
  input  logic               id_ready,
  output rv32_instr_packet_t instruction_packet,
  output logic               id_illegal,
  output logic [CNT_W-1:0]   decode_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  rv32_if_packet_t    fifo_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]     count_reg, count_next;
  logic               id_valid_reg, id_illegal_reg;
  rv32_instr_packet_t packet_reg;
  logic [CNT_W-1:0]   decode_count_reg;

  logic               push, pop, handshake;
  rv32_if_packet_t    head;
  rv32_instr_packet_t dec;
  logic               dec_illegal;

  logic [31:0] instr;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd_idx, rs1_idx, rs2_idx;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign if_ready  = (count_reg != DEPTH_CNT);
  assign handshake = id_valid_reg && id_ready;
  assign push      = if_valid && if_ready && !flush;
  assign pop       = (count_reg != '0) && (!id_valid_reg || id_ready) && !flush;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  // Packet storage carries no reset; occupancy is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= if_packet;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      count_reg <= count_next;
    end
  end

  assign head    = fifo_mem[rd_ptr_reg];
  assign instr   = head.instr;
  assign opc     = instr[6:0];
  assign rd_idx  = instr[11:7];
  assign f3      = instr[14:12];
  assign rs1_idx = instr[19:15];
  assign rs2_idx = instr[24:20];
  assign f7      = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Illegal encodings keep their format's fields but decode to NOP and still flow downstream.
  always_comb begin
    dec              = '0;
    dec.pc           = head.pc;
    dec.valid_opcode = rv32_pkg::valid_opcode(opc);
    dec.dont_forward = rv32_pkg::dont_forward(opc);
    dec.alu_op       = ALU_OP_NOP;
    dec_illegal      = 1'b0;
    case (opc)
      OPC_LUI: begin
        dec.rd     = rd_idx;
        dec.imm32  = imm_u;
        dec.alu_op = ALU_OP_LUI;
      end
      OPC_AUIPC: begin
        dec.rd     = rd_idx;
        dec.imm32  = imm_u;
        dec.alu_op = ALU_OP_AUIPC;
      end
      OPC_JAL: begin
        dec.rd     = rd_idx;
        dec.imm32  = imm_j;
        dec.alu_op = ALU_OP_JAL;
      end
      OPC_JALR: begin
        dec.rs1   = rs1_idx;
        dec.rd    = rd_idx;
        dec.imm32 = imm_i;
        if (f3 == 3'b000) dec.alu_op = ALU_OP_JALR;
        else              dec_illegal = 1'b1;
      end
      OPC_BRANCH: begin
        dec.rs1   = rs1_idx;
        dec.rs2   = rs2_idx;
        dec.imm32 = imm_b;
        case (f3)
          3'b000:  dec.alu_op = ALU_OP_BEQ;
          3'b001:  dec.alu_op = ALU_OP_BNE;
          3'b100:  dec.alu_op = ALU_OP_BLT;
          3'b101:  dec.alu_op = ALU_OP_BGE;
          3'b110:  dec.alu_op = ALU_OP_BLTU;
          3'b111:  dec.alu_op = ALU_OP_BGEU;
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.rs1   = rs1_idx;
        dec.rd    = rd_idx;
        dec.imm32 = imm_i;
        case (f3)
          3'b000:  dec.alu_op = ALU_OP_LB;
          3'b001:  dec.alu_op = ALU_OP_LH;
          3'b010:  dec.alu_op = ALU_OP_LW;
          3'b100:  dec.alu_op = ALU_OP_LBU;
          3'b101:  dec.alu_op = ALU_OP_LHU;
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec.rs1   = rs1_idx;
        dec.rs2   = rs2_idx;
        dec.imm32 = imm_s;
        case (f3)
          3'b000:  dec.alu_op = ALU_OP_SB;
          3'b001:  dec.alu_op = ALU_OP_SH;
          3'b010:  dec.alu_op = ALU_OP_SW;
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        dec.rs1   = rs1_idx;
        dec.rd    = rd_idx;
        dec.imm32 = imm_i;
        case (f3)
          3'b000: dec.alu_op = ALU_OP_ADDI;
          3'b010: dec.alu_op = ALU_OP_SLTI;
          3'b011: dec.alu_op = ALU_OP_SLTIU;
          3'b100: dec.alu_op = ALU_OP_XORI;
          3'b110: dec.alu_op = ALU_OP_ORI;
          3'b111: dec.alu_op = ALU_OP_ANDI;
          3'b001: begin
            if (f7 == 7'b0000000) dec.alu_op = ALU_OP_SLLI;
            else                  dec_illegal = 1'b1;
          end
          default: begin
            if (f7 == 7'b0000000)      dec.alu_op = ALU_OP_SRLI;
            else if (f7 == 7'b0100000) dec.alu_op = ALU_OP_SRAI;
            else                       dec_illegal = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        dec.rs1 = rs1_idx;
        dec.rs2 = rs2_idx;
        dec.rd  = rd_idx;
        case (f7)
          7'b0000000: begin
            case (f3)
              3'b000:  dec.alu_op = ALU_OP_ADD;
              3'b001:  dec.alu_op = ALU_OP_SLL;
              3'b010:  dec.alu_op = ALU_OP_SLT;
              3'b011:  dec.alu_op = ALU_OP_SLTU;
              3'b100:  dec.alu_op = ALU_OP_XOR;
              3'b101:  dec.alu_op = ALU_OP_SRL;
              3'b110:  dec.alu_op = ALU_OP_OR;
              default: dec.alu_op = ALU_OP_AND;
            endcase
          end
          7'b0100000: begin
            case (f3)
              3'b000:  dec.alu_op = ALU_OP_SUB;
              3'b101:  dec.alu_op = ALU_OP_SRA;
              default: dec_illegal = 1'b1;
            endcase
          end
`ifdef RV32M_DECODE_EN
          7'b0000001: begin
            case (f3)
              3'b000:  dec.alu_op = ALU_OP_MUL;
              3'b001:  dec.alu_op = ALU_OP_MULH;
              3'b010:  dec.alu_op = ALU_OP_MULHSU;
              3'b011:  dec.alu_op = ALU_OP_MULHU;
              3'b100:  dec.alu_op = ALU_OP_DIV;
              3'b101:  dec.alu_op = ALU_OP_DIVU;
              3'b110:  dec.alu_op = ALU_OP_REM;
              default: dec.alu_op = ALU_OP_REMU;
            endcase
          end
`endif
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid_reg     <= 1'b0;
      id_illegal_reg   <= 1'b0;
      packet_reg       <= '0;
      decode_count_reg <= '0;
    end else if (flush) begin
      id_valid_reg   <= 1'b0;
      id_illegal_reg <= 1'b0;
      packet_reg     <= '0;
    end else begin
      if (handshake) decode_count_reg <= decode_count_reg + CNT_W'(1);
      if (pop) begin
        id_valid_reg   <= 1'b1;
        id_illegal_reg <= dec_illegal;
        packet_reg     <= dec;
      end else if (handshake) begin
        id_valid_reg <= 1'b0;
      end
    end
  end

  assign id_valid           = id_valid_reg;
  assign id_illegal         = id_illegal_reg;
  assign instruction_packet = packet_reg;
  assign decode_count       = decode_count_reg;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count_reg <= DEPTH_CNT);
  a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (id_valid_reg && !id_ready && !flush) |=> ($stable(packet_reg) && $stable(id_illegal_reg)));

endmodule
